// File: rtl/dec_pkg.sv
// ----------------------------------------------------------------------------
// dec_pkg
// Shared widths and types for the one-hot select decoder.
//   DEC_IN_W     : binary select width
//   DEC_OUT_W    : one-hot output width (2**DEC_IN_W)
//   dec_sel_t    : binary select type
//   dec_onehot_t : one-hot line vector type
// ----------------------------------------------------------------------------
package dec_pkg;

   localparam int unsigned DEC_IN_W  = 3;
   localparam int unsigned DEC_OUT_W = 8;

   typedef logic [DEC_IN_W-1:0]  dec_sel_t;
   typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

endpackage : dec_pkg

// File: rtl/dec_core.sv
// ----------------------------------------------------------------------------
// dec_core
// Purely combinational binary-to-one-hot decoder with enable.
// Ports:
//   a      in   IN_W       binary select, bit 0 is the LSB
//   en     in   1          decode enable, active-high
//   onehot out  2**IN_W    bit a set when en=1, all zero when en=0
// ----------------------------------------------------------------------------
module dec_core
   import dec_pkg::*;
#(
   parameter int unsigned IN_W = DEC_IN_W
) (
   input  logic [IN_W-1:0]      a,
   input  logic                 en,
   output logic [(2**IN_W)-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[a] = 1'b1;
      end
   end

endmodule : dec_core

// File: rtl/dec_3_to_8.sv
// ----------------------------------------------------------------------------
// dec_3_to_8
// Registered 3-to-8 one-hot decoder with active-high enable. The decoded
// lines are captured on the rising edge so downstream select/strobe logic
// sees a glitch-free one-hot bus with exactly one clock of latency.
// Ports:
//   clk  in   1       clock, rising edge
//   rst  in   1       synchronous active-high reset, clears y
//   en   in   1       decode enable; en=0 drives y to zero on the next edge
//   a    in   IN_W    binary select
//   y    out  OUT_W   registered one-hot lines, bit i set for a==i
// ----------------------------------------------------------------------------
module dec_3_to_8
   import dec_pkg::*;
#(
   parameter int unsigned IN_W = DEC_IN_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [IN_W-1:0]         a,
   output logic [(2**IN_W)-1:0]    y
);

   localparam int unsigned OUT_W = 2**IN_W;

   logic [OUT_W-1:0] y_d;
   logic [OUT_W-1:0] y_q;

   dec_core #(
      .IN_W (IN_W)
   ) u_dec_core (
      .a      (a),
      .en     (en),
      .onehot (y_d)
   );

   // rst wins over en/a, so a reset edge always yields an all-zero bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q <= '0;
      end else begin
         y_q <= y_d;
      end
   end

   assign y = y_q;

`ifndef SYNTHESIS
   // y is undefined until the first reset edge; hold off the checks until then.
   logic rst_seen_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rst_seen_q <= 1'b1;
      end else if (rst_seen_q !== 1'b1) begin
         rst_seen_q <= 1'b0;
      end
   end

   a_onehot0 : assert property (@(posedge clk) (rst_seen_q === 1'b1) |-> $onehot0(y))
      else $error("y not one-hot-or-zero: %b", y);

   a_clear : assert property (@(posedge clk) (rst || !en) |=> (y == '0))
      else $error("y not cleared after rst or !en: %b", y);
`endif

endmodule : dec_3_to_8

// File: tb/tb_dec_3_to_8.sv
// ----------------------------------------------------------------------------
// tb_dec_3_to_8
// Self-checking bench for dec_3_to_8: directed vectors with hand-computed
// expected values, followed by a randomised run against a one-cycle model.
// ----------------------------------------------------------------------------
module tb_dec_3_to_8;
   import dec_pkg::*;

   logic        clk;
   logic        rst;
   logic        en;
   dec_sel_t    a;
   dec_onehot_t y;

   int unsigned n_checks;
   int unsigned n_errors;

   dec_3_to_8 u_dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (a),
      .y   (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input dec_onehot_t got, input dec_onehot_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Drive inputs away from the active edge, then sample y just after it.
   task automatic step(input string tag, input logic r, input logic e, input dec_sel_t s,
                       input dec_onehot_t exp);
      @(negedge clk);
      rst = r;
      en  = e;
      a   = s;
      @(posedge clk);
      #1;
      check_eq(tag, y, exp);
   endtask

   dec_onehot_t en_exp [8];
   dec_onehot_t model;
   dec_onehot_t ones;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      en  = 1'b1;
      a   = 3'd5;

      en_exp[0] = 8'b0000_0001;
      en_exp[1] = 8'b0000_0010;
      en_exp[2] = 8'b0000_0100;
      en_exp[3] = 8'b0000_1000;
      en_exp[4] = 8'b0001_0000;
      en_exp[5] = 8'b0010_0000;
      en_exp[6] = 8'b0100_0000;
      en_exp[7] = 8'b1000_0000;

      // Reset holds y at zero despite en=1, a=5; release shows a=5.
      step("reset_0", 1'b1, 1'b1, 3'd5, 8'b0000_0000);
      step("reset_1", 1'b1, 1'b1, 3'd5, 8'b0000_0000);
      step("reset_release", 1'b0, 1'b1, 3'd5, 8'b0010_0000);

      // Enabled sweep, a=7 must land on the MSB.
      for (int i = 0; i < 8; i++) begin
         step($sformatf("en_sweep_a%0d", i), 1'b0, 1'b1, dec_sel_t'(i), en_exp[i]);
      end

      // Disabled sweep.
      for (int i = 0; i < 8; i++) begin
         step($sformatf("dis_sweep_a%0d", i), 1'b0, 1'b0, dec_sel_t'(i), 8'b0000_0000);
      end

      // Enable toggle with a new select on the rising-enable edge.
      step("toggle_on_a3", 1'b0, 1'b1, 3'd3, 8'b0000_1000);
      step("toggle_off", 1'b0, 1'b0, 3'd3, 8'b0000_0000);
      step("toggle_on_a6", 1'b0, 1'b1, 3'd6, 8'b0100_0000);

      // a changes on the same edge en falls.
      step("en_fall_a_chg", 1'b0, 1'b0, 3'd1, 8'b0000_0000);

      // Unknown select while disabled must not reach y.
      step("dis_a_x", 1'b0, 1'b0, 3'bxxx, 8'b0000_0000);

      // Mid-run reset pulse.
      step("midrst_pre", 1'b0, 1'b1, 3'd7, 8'b1000_0000);
      step("midrst_pulse", 1'b1, 1'b1, 3'd7, 8'b0000_0000);
      step("midrst_post", 1'b0, 1'b1, 3'd7, 8'b1000_0000);

      // Random run against the one-cycle model.
      for (int i = 0; i < 1000; i++) begin
         logic     r_r;
         logic     r_e;
         dec_sel_t r_a;
         r_r = ($urandom_range(15) == 0);
         r_e = 1'($urandom_range(1));
         r_a = dec_sel_t'($urandom_range(7));
         model = r_r ? 8'b0 : (r_e ? (8'b1 << r_a) : 8'b0);
         step($sformatf("rand_%0d", i), r_r, r_e, r_a, model);
         ones = $onehot0(y) ? 8'd1 : 8'd0;
         check_eq($sformatf("rand_onehot0_%0d", i), ones, 8'd1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_dec_3_to_8
